pwm_gate_monitor: RTL and testbench

PWM_GATE_MONITOR -- requirements
Module: pwm_gate_monitor

---
 rtl/pwm_gate_monitor_pkg.sv | 14 +
 rtl/pwm_gate_monitor_edge_sync.sv | 40 ++++
 rtl/pwm_gate_monitor.sv | 159 +++++++++++++++
 tb/tb_pwm_gate_monitor.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_gate_monitor_pkg.sv
// Shared types and defaults for the PWM gate monitor.
// Optional build macro: PWM_MON_SYNC_EN (2-flop input synchronizers).
package pwm_gate_monitor_pkg;

  localparam int DEF_CNT_W = 10;
  localparam int DEF_DT_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_e;

endpackage

// File: rtl/pwm_gate_monitor_edge_sync.sv
// One gate input: optional 2-flop synchronizer, delayed copy, rise/fall flags.
// Optional build macro: PWM_MON_SYNC_EN (adds 2 cycles of input latency).
module pwm_edge_sync (
  input  logic clk,
  input  logic resetn,
  input  logic d_i,
  output logic gs_o,
  output logic rise_o,
  output logic fall_o
);

  logic gs;
  logic gs_d_q;

`ifdef PWM_MON_SYNC_EN
  logic [1:0] sync_q;

  // Two-stage synchronizer for asynchronous gate pins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync_q <= 2'b00;
    else         sync_q <= {sync_q[0], d_i};
  end

  assign gs = sync_q[1];
`else
  // Gate comes from a same-clock source; sample directly.
  assign gs = d_i;
`endif

  // One-cycle delayed copy used for edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) gs_d_q <= 1'b0;
    else         gs_d_q <= gs;
  end

  assign gs_o   = gs;
  assign rise_o = gs & ~gs_d_q;
  assign fall_o = ~gs & gs_d_q;

endmodule

// File: rtl/pwm_gate_monitor.sv
// PWM gate monitor: measures period, on-time and both dead times of a
// high/low gate pair, flags shoot-through overlap and a stuck high-side gate.
// Optional build macro: PWM_MON_SYNC_EN (synchronize gate inputs).
module pwm_gate_monitor
  import pwm_gate_monitor_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int DT_W  = DEF_DT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             gate_hi,
  input  logic             gate_lo,
  input  logic             fault_clr,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] on_cnt,
  output logic [DT_W-1:0]  dt1_cnt,
  output logic [DT_W-1:0]  dt2_cnt,
  output logic             meas_valid,
  output logic             overlap_fault,
  output logic             stuck
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DT_W-1:0]  DT_MAX  = '1;

  logic gs_hi, hi_rise, hi_fall;
  logic gs_lo, lo_rise_unused, lo_fall;

  pwm_edge_sync u_hi (
    .clk(clk), .resetn(resetn), .d_i(gate_hi),
    .gs_o(gs_hi), .rise_o(hi_rise), .fall_o(hi_fall)
  );

  pwm_edge_sync u_lo (
    .clk(clk), .resetn(resetn), .d_i(gate_lo),
    .gs_o(gs_lo), .rise_o(lo_rise_unused), .fall_o(lo_fall)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] per_q, per_d, on_q, on_d;
  logic [DT_W-1:0]  dt1_q, dt1_d, dt2_q, dt2_d;
  logic             tag_q, tag_d;          // 1: gate_hi fell most recently
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d, on_cnt_q, on_cnt_d;
  logic [DT_W-1:0]  dt1_cnt_q, dt1_cnt_d, dt2_cnt_q, dt2_cnt_d;
  logic             meas_valid_q, meas_valid_d;
  logic             overlap_q, overlap_d, stuck_q, stuck_d;
  logic             stuck_set, tag_eff, both_low;

  // A fall in this cycle overrides the stored tag; hi wins a simultaneous fall.
  assign tag_eff  = hi_fall ? 1'b1 : (lo_fall ? 1'b0 : tag_q);
  assign both_low = ~gs_hi & ~gs_lo;

  // Next-state, counter and publish logic.
  always_comb begin
    state_d      = state_q;
    per_d        = '0;
    on_d         = '0;
    dt1_d        = '0;
    dt2_d        = '0;
    tag_d        = tag_eff;
    period_cnt_d = period_cnt_q;
    on_cnt_d     = on_cnt_q;
    dt1_cnt_d    = dt1_cnt_q;
    dt2_cnt_d    = dt2_cnt_q;
    meas_valid_d = 1'b0;
    stuck_set    = 1'b0;
    if (!en) begin
      state_d = IDLE;
      tag_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          if (hi_rise) begin
            state_d = MEAS;
            per_d   = CNT_ONE;
            on_d    = CNT_ONE;
          end
        end
        MEAS: begin
          if (hi_rise) begin
            // Rise cycle is cycle 0 of the new period and is already high.
            period_cnt_d = per_q;
            on_cnt_d     = on_q;
            dt1_cnt_d    = dt1_q;
            dt2_cnt_d    = dt2_q;
            meas_valid_d = 1'b1;
            per_d        = CNT_ONE;
            on_d         = CNT_ONE;
          end else if (per_q == CNT_MAX) begin
            stuck_set = 1'b1;
            state_d   = ARM;
          end else begin
            per_d = per_q + 1'b1;
            on_d  = on_q;
            dt1_d = dt1_q;
            dt2_d = dt2_q;
            if (gs_hi && on_q != CNT_MAX) on_d = on_q + 1'b1;
            if (both_low) begin
              if (tag_eff) begin
                if (dt2_q != DT_MAX) dt2_d = dt2_q + 1'b1;
              end else begin
                if (dt1_q != DT_MAX) dt1_d = dt1_q + 1'b1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    overlap_d = (en & gs_hi & gs_lo) ? 1'b1 : (fault_clr ? 1'b0 : overlap_q);
    stuck_d   = stuck_set ? 1'b1 : (fault_clr ? 1'b0 : stuck_q);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      per_q        <= '0;
      on_q         <= '0;
      dt1_q        <= '0;
      dt2_q        <= '0;
      tag_q        <= 1'b0;
      period_cnt_q <= '0;
      on_cnt_q     <= '0;
      dt1_cnt_q    <= '0;
      dt2_cnt_q    <= '0;
      meas_valid_q <= 1'b0;
      overlap_q    <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_q        <= per_d;
      on_q         <= on_d;
      dt1_q        <= dt1_d;
      dt2_q        <= dt2_d;
      tag_q        <= tag_d;
      period_cnt_q <= period_cnt_d;
      on_cnt_q     <= on_cnt_d;
      dt1_cnt_q    <= dt1_cnt_d;
      dt2_cnt_q    <= dt2_cnt_d;
      meas_valid_q <= meas_valid_d;
      overlap_q    <= overlap_d;
      stuck_q      <= stuck_d;
    end
  end

  assign period_cnt    = period_cnt_q;
  assign on_cnt        = on_cnt_q;
  assign dt1_cnt       = dt1_cnt_q;
  assign dt2_cnt       = dt2_cnt_q;
  assign meas_valid    = meas_valid_q;
  assign overlap_fault = overlap_q;
  assign stuck         = stuck_q;

endmodule

// File: tb/tb_pwm_gate_monitor.sv
// Directed bench for pwm_gate_monitor with a measurement scoreboard.
module tb_pwm_gate_monitor;

  localparam int CNT_W = 10;
  localparam int DT_W  = 5;
`ifdef PWM_MON_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic             clk = 1'b0;
  logic             resetn, en, gate_hi, gate_lo, fault_clr;
  logic [CNT_W-1:0] period_cnt, on_cnt;
  logic [DT_W-1:0]  dt1_cnt, dt2_cnt;
  logic             meas_valid, overlap_fault, stuck;

  pwm_gate_monitor #(.CNT_W(CNT_W), .DT_W(DT_W)) dut (
    .clk(clk), .resetn(resetn), .en(en), .gate_hi(gate_hi), .gate_lo(gate_lo),
    .fault_clr(fault_clr), .period_cnt(period_cnt), .on_cnt(on_cnt),
    .dt1_cnt(dt1_cnt), .dt2_cnt(dt2_cnt), .meas_valid(meas_valid),
    .overlap_fault(overlap_fault), .stuck(stuck)
  );

  always #5 clk = ~clk;

  typedef struct { int per; int on; int dt1; int dt2; } meas_t;

  meas_t exp_q[$];
  meas_t pending;
  bit    armed = 1'b0;
  int    n_assert = 0;
  int    n_fail = 0;

  task automatic chk(input string tag, input int obs, input int expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Scoreboard: every meas_valid pops one expected measurement.
  initial begin
    meas_t e;
    bit prev_mv = 1'b0;
    forever begin
      @(negedge clk);
      if (resetn && meas_valid) begin
        chk("mv_width", int'(prev_mv), 0);
        if (exp_q.size() == 0) chk("unexpected_meas_valid", int'(meas_valid), 0);
        else begin
          e = exp_q.pop_front();
          chk("period_cnt", int'(period_cnt), e.per);
          chk("on_cnt", int'(on_cnt), e.on);
          chk("dt1_cnt", int'(dt1_cnt), e.dt1);
          chk("dt2_cnt", int'(dt2_cnt), e.dt2);
        end
      end
      prev_mv = resetn && meas_valid;
    end
  end

  // Hold gate levels for n clocks; returns 1 time unit after an edge.
  task automatic run(input logic h, input logic l, input int n);
    gate_hi = h;
    gate_lo = l;
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // One PWM period starting with a hi rise; that rise closes the previous one.
  task automatic do_period(input int on, input int dta, input int dtb, input int tot);
    meas_t m;
    if (armed) exp_q.push_back(pending);
    m.per = tot;
    m.on  = on;
    m.dt2 = (dta > 31) ? 31 : dta;
    m.dt1 = (dtb > 31) ? 31 : dtb;
    pending = m;
    armed   = 1'b1;
    run(1'b1, 1'b0, on);
    run(1'b0, 1'b0, dta);
    run(1'b0, 1'b1, tot - on - dta - dtb);
    run(1'b0, 1'b0, dtb);
  endtask

  task automatic close_meas();
    if (armed) exp_q.push_back(pending);
    armed = 1'b0;
    run(1'b1, 1'b0, 3 + LAT);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_period"}, int'(period_cnt), 0);
    chk({pfx, "_on"}, int'(on_cnt), 0);
    chk({pfx, "_dt1"}, int'(dt1_cnt), 0);
    chk({pfx, "_dt2"}, int'(dt2_cnt), 0);
    chk({pfx, "_valid"}, int'(meas_valid), 0);
    chk({pfx, "_overlap"}, int'(overlap_fault), 0);
    chk({pfx, "_stuck"}, int'(stuck), 0);
  endtask

  initial begin
    resetn = 1'b0; en = 1'b0; gate_hi = 1'b0; gate_lo = 1'b0; fault_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    resetn = 1'b1;
    run(1'b0, 1'b0, 2);

    // Nominal and varied periods, including dead-time saturation.
    en = 1'b1;
    run(1'b0, 1'b0, 4);
    repeat (4) do_period(100, 3, 4, 250);
    repeat (2) do_period(37, 5, 2, 120);
    repeat (2) do_period(20, 40, 1, 100);
    close_meas();
    en = 1'b0;
    run(1'b0, 1'b0, 6);
    chk("hold_period", int'(period_cnt), 100);
    chk("hold_on", int'(on_cnt), 20);
    chk("hold_dt1", int'(dt1_cnt), 1);
    chk("hold_dt2", int'(dt2_cnt), 31);

    // Overlap: set, hold, clear, and clear losing to a concurrent set.
    en = 1'b1;
    run(1'b0, 1'b0, 3);
    chk("overlap_init", int'(overlap_fault), 0);
    run(1'b1, 1'b1, 1);
    run(1'b1, 1'b0, 1 + LAT);
    chk("overlap_set", int'(overlap_fault), 1);
    run(1'b1, 1'b0, 5);
    chk("overlap_held", int'(overlap_fault), 1);
    fault_clr = 1'b1;
    run(1'b1, 1'b0, 1);
    fault_clr = 1'b0;
    chk("overlap_clr", int'(overlap_fault), 0);
    fault_clr = 1'b1;
    run(1'b1, 1'b1, 1 + LAT);
    fault_clr = 1'b0;
    chk("overlap_set_wins", int'(overlap_fault), 1);
    run(1'b1, 1'b0, 2 + LAT);
    chk("overlap_sticky", int'(overlap_fault), 1);
    en = 1'b0;
    run(1'b0, 1'b0, 4);
    fault_clr = 1'b1;
    run(1'b0, 1'b0, 1);
    fault_clr = 1'b0;
    chk("overlap_clr_idle", int'(overlap_fault), 0);

    // Stuck: no rise for >1023 cycles in MEAS, then recovery.
    en = 1'b1;
    run(1'b0, 1'b0, 3);
    run(1'b1, 1'b0, 10);
    run(1'b0, 1'b0, 1000);
    chk("stuck_not_yet", int'(stuck), 0);
    run(1'b0, 1'b0, 100);
    chk("stuck_set", int'(stuck), 1);
    fault_clr = 1'b1;
    run(1'b0, 1'b0, 1);
    fault_clr = 1'b0;
    chk("stuck_clr", int'(stuck), 0);
    armed = 1'b0;
    do_period(50, 2, 2, 80);
    do_period(60, 3, 3, 90);
    do_period(70, 1, 6, 150);

    // Reset in the middle of a period discards it; re-arm needs two rises.
    if (armed) exp_q.push_back(pending);
    armed = 1'b0;
    run(1'b1, 1'b0, 3 + LAT);
    run(1'b1, 1'b0, 30);
    resetn = 1'b0;
    #1;
    chk_zero("mid_reset");
    run(1'b0, 1'b0, 3);
    resetn = 1'b1;
    run(1'b0, 1'b0, 3);
    repeat (2) do_period(100, 3, 4, 250);
    close_meas();
    en = 1'b0;
    run(1'b0, 1'b0, 5);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
